// File: rtl/regfile_banked.sv
`default_nettype none
// ============================================================================
// Module      : regfile_banked
// Description : Bank-switched index register file with FIN-style pair loader
//               and an in-place increment path carrying a registered wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_banked #(
  parameter int DW      = 4,
  parameter int NREG    = 16,
  parameter int NBANKED = 8,
  parameter int NBANK   = 2,
  localparam int IW     = $clog2(NREG),
  localparam int BW     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic [IW-1:0]   idx,
  output logic [DW-1:0]   rn,
  output logic [2*DW-1:0] rp,
  output logic            rn_zero,
  input  logic            wr_en,
  input  logic [DW-1:0]   wr_data,
  input  logic            pair_we,
  input  logic [2*DW-1:0] pair_data,
  input  logic            inc_en,
  output logic            inc_wrap,
  input  logic            bank_we,
  input  logic [BW-1:0]   bank_d,
  output logic [BW-1:0]   bank,
  input  logic            fin_start,
  input  logic            fin_abort,
  input  logic            data_valid,
  input  logic [DW-1:0]   data_i,
  output logic            fin_busy,
  output logic            fin_done
);

  localparam int NPHYS = NBANKED * NBANK + (NREG - NBANKED);
  localparam int PW    = (NPHYS > 1) ? $clog2(NPHYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  logic [DW-1:0] r_regs [NPHYS];
  logic [BW-1:0] r_bank;
  logic [BW-1:0] r_tbank;
  logic [IW-1:0] r_tgt;
  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_wrap;

  // Low logical registers are replicated per bank; the rest live after all banks.
  function automatic logic [PW-1:0] phys(input logic [IW-1:0] i, input logic [BW-1:0] b);
    int unsigned ii;
    int unsigned bb;
    ii = 32'(i);
    bb = 32'(b);
    if (ii < NBANKED)
      phys = PW'(bb * NBANKED + ii);
    else
      phys = PW'(NBANKED * NBANK + ii - NBANKED);
  endfunction

  logic [IW-1:0] w_idx_even;
  logic [IW-1:0] w_idx_odd;
  logic [IW-1:0] w_tgt_odd;
  logic [PW-1:0] w_rn_addr;
  logic [PW-1:0] w_even_addr;
  logic [PW-1:0] w_odd_addr;
  logic [DW-1:0] w_rn;

  assign w_idx_even  = idx & ~IW'(1);
  assign w_idx_odd   = idx | IW'(1);
  assign w_tgt_odd   = r_tgt | IW'(1);
  assign w_rn_addr   = phys(idx, r_bank);
  assign w_even_addr = phys(w_idx_even, r_bank);
  assign w_odd_addr  = phys(w_idx_odd, r_bank);
  assign w_rn        = r_regs[w_rn_addr];

  assign rn       = w_rn;
  assign rp       = {r_regs[w_even_addr], r_regs[w_odd_addr]};
  assign rn_zero  = (w_rn == '0);
  assign bank     = r_bank;
  assign fin_busy = r_busy;
  assign fin_done = r_done;
  assign inc_wrap = r_wrap;

  // A beat is offered whenever the loader waits and no abort overrides it.
  logic w_beat;
  logic w_beat_acc;
  logic w_inc_acc;

  assign w_beat     = data_valid && !fin_abort && (r_state != S_IDLE);
  assign w_beat_acc = w_beat && !pair_we;
  assign w_inc_acc  = inc_en && !pair_we && !w_beat;

  logic          w_we_a;
  logic          w_we_b;
  logic [PW-1:0] w_addr_a;
  logic [PW-1:0] w_addr_b;
  logic [DW-1:0] w_data_a;
  logic [DW-1:0] w_data_b;

  always_comb begin
    w_we_a   = 1'b0;
    w_we_b   = 1'b0;
    w_addr_a = w_rn_addr;
    w_addr_b = w_odd_addr;
    w_data_a = wr_data;
    w_data_b = pair_data[DW-1:0];
    if (pair_we) begin
      w_we_a   = 1'b1;
      w_we_b   = 1'b1;
      w_addr_a = w_even_addr;
      w_data_a = pair_data[2*DW-1:DW];
    end else if (w_beat) begin
      w_we_a   = 1'b1;
      w_addr_a = (r_state == S_HI) ? phys(r_tgt, r_tbank) : phys(w_tgt_odd, r_tbank);
      w_data_a = data_i;
    end else if (inc_en) begin
      w_we_a   = 1'b1;
      w_data_a = w_rn + DW'(1);
    end else if (wr_en) begin
      w_we_a   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int k = 0; k < NPHYS; k++)
        r_regs[k] <= '0;
    end else begin
      if (w_we_a)
        r_regs[w_addr_a] <= w_data_a;
      if (w_we_b)
        r_regs[w_addr_b] <= w_data_b;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_bank <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (bank_we && (32'(bank_d) < NBANK))
        r_bank <= bank_d;
      if (w_inc_acc)
        r_wrap <= (w_rn == {DW{1'b1}});
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tgt   <= '0;
      r_tbank <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fin_start) begin
            r_tgt   <= w_idx_even;
            r_tbank <= r_bank;
            r_state <= S_HI;
            r_busy  <= 1'b1;
          end
        end
        S_HI: begin
          if (fin_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_beat_acc) begin
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (fin_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_beat_acc) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Parametrised successor to the CPU index register file.
- Adds:
  - N-bit data width and configurable register count.
  - Bank-switched low registers: logical R0..R(NBANKED-1) map per bank; the remainder are common to all banks.
  - A handshaked two-beat FIN-style pair loader FSM.
  - An in-place increment path with a registered wrap flag for ISZ-type instructions.
- Sits between the decoder/ALU and the data bus; it is the sole owner of index register state.

Parameters:
- DW, 4, data width of one register.
- NREG, 16, logical registers visible to instructions; even, power of two.
- NBANKED, 8, low logical registers replicated per bank; even, at most NREG.
- NBANK, 2, number of banks; power of two, at least 1.
- Derived: IW = clog2(NREG); BW = max(1, clog2(NBANK)); physical count = NBANKED*NBANK + (NREG-NBANKED).

Ports:
- CLK  in  1  system clock.
- RES  in  1  asynchronous active-high reset.
- idx  in  IW  logical register index from the decoder; bit 0 is ignored for pair operations.
- rn  out  DW  combinational read of register idx in the current bank.
- rp  out  2*DW  combinational pair read: {R[idx&~1], R[idx|1]}.
- rn_zero  out  1  rn == 0.
- wr_en  in  1  write wr_data to R[idx].
- wr_data  in  DW  single-register write data (ALU/ACC result).
- pair_we  in  1  write pair_data to pair idx (FIM).
- pair_data  in  2*DW  high half goes to the even register, low half to the odd register.
- inc_en  in  1  R[idx] <= R[idx]+1 mod 2^DW.
- inc_wrap  out  1  registered; 1 when the last inc_en result was 0.
- bank_we  in  1  load the bank select register.
- bank_d  in  BW  new bank number.
- bank  out  BW  current bank select.
- fin_start  in  1  begin a pair load into pair idx.
- fin_abort  in  1  cancel an in-flight pair load.
- data_valid  in  1  a data_i beat is present.
- data_i  in  DW  bus nibble.
- fin_busy  out  1  loader not IDLE.
- fin_done  out  1  one-cycle pulse after the second beat is written.

Behaviour:
- Reset (RES=1, asynchronous):
  - All physical registers = 0; bank = 0; loader IDLE.
  - fin_busy = 0, fin_done = 0, inc_wrap = 0.
  - Hence rn = 0, rp = 0, rn_zero = 1.
  - Reset asserted mid-load discards the load immediately.
- Address map:
  - idx < NBANKED: phys = bank*NBANKED + idx.
  - Otherwise: phys = NBANKED*NBANK + (idx - NBANKED).
  - Reads use the live bank.
- Bank select:
  - bank_we loads bank_d on the next edge.
  - bank_d >= NBANK is ignored; bank holds.
  - New bank affects reads the cycle after the edge.
- Write priority, one register-file write per cycle:
  - pair_we > loader beat > inc_en > wr_en.
  - Lower-priority requests that cycle are dropped.
  - Exception: a loader beat blocked by pair_we is not consumed; the FSM stays put, and the source must hold data_valid.
- inc_en:
  - Writes R[idx]+1, truncated to DW.
  - inc_wrap <= (R[idx] == 2^DW-1), updated only on cycles where inc_en is accepted.
  - Otherwise inc_wrap holds.
- Loader FSM states: IDLE, HI, LO.
  - IDLE: fin_start latches tgt = idx&~1 and tbank = bank, then moves to HI.
  - HI: when data_valid is accepted, writes data_i to R[tgt] in tbank, then moves to LO.
  - LO: when data_valid is accepted, writes data_i to R[tgt|1] in tbank, then moves to IDLE with fin_done = 1 for exactly one cycle.
  - fin_abort in HI or LO: returns to IDLE with no write that cycle; an already-written high beat remains; no fin_done.
  - fin_abort has priority over a concurrent beat.
  - fin_start while busy is ignored.
  - fin_start and fin_abort together in IDLE: start wins.
  - Bank changes during a load do not redirect it; the latched tbank is used.
  - data_valid in IDLE is ignored.
- Latency:
  - All writes are visible on rn/rp the cycle after the edge.
  - No same-cycle bypass.
- Registers with idx >= NBANKED are common to all banks: a write in one bank is visible from all others.

Test Plan:
- Reset then read all idx → rn = 0, rn_zero = 1, bank = 0, fin_busy = 0.
- pair_we idx=5 pair_data=0xA3 (bank 0) → next cycle rp for idx=4 = 0xA3; R4 = 0xA, R5 = 0x3.
- Write R2=0x7 in bank 0; bank_we bank_d=1; read idx 2 → 0; write R2=0xC; R9=0x5 written in bank 1 → back in bank 0, idx 2 = 0x7, idx 9 = 0x5.
- fin_start idx=3, beats 0x1 then 0xE with a 2-cycle data_valid gap; bank switched to 1 between beats → bank 0 R2 = 0x1, R3 = 0xE; fin_done pulses once; fin_busy 3+ cycles.
- inc_en on R6=0xF → R6 = 0, inc_wrap = 1; again → R6 = 1, inc_wrap = 0; inc_en with wr_en same cycle → only the increment lands.
- fin_start then HI beat 0x4, then fin_abort with data_valid asserted → R[tgt] = 0x4, odd register unchanged, no fin_done; RES pulse during HI → IDLE, all registers 0.
